nn_mat_loader: RTL and testbench
================================

Name: nn_mat_loader

Overview:
- Host-side sequencer for the matrix-load pin interface of the 2x2 predictor core (mat_sel / adr / w2 in, 3-bit decision out).
- Accepts a stream of signed 21-bit words over a valid/ready handshake and emits one predictor write cycle per word:
  - input matrix (mat_sel 00), then hidden weights (01), then output weights (10);
  - within each matrix, adr 0..3 in row-major order, adr[1] = row.
- After the last write and a settle delay, captures decision and reports it with a one-cycle result strobe.

Parameters:
- DATA_W, 21, width of in_data and w2.
- SETTLE_CYCLES, 2, cycles from the last write cycle to decision capture; legal range 1..15.

Ports:
- wb_clk_i  input  1  clock, all logic on rising edge.
- wb_rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a load sequence; honoured only in IDLE.
- reload_weights  input  1  sampled with start. 1 = load all 12 words. 0 = load the 4 input-matrix words only; the predictor keeps its weights.
- abort  input  1  cancel the sequence in progress.
- in_valid  input  1  word available on in_data.
- in_ready  output  1  loader accepts the word this cycle.
- in_data  input  DATA_W  signed word.
- mat_sel  output  2  predictor matrix select; 2'b11 = no write.
- adr  output  2  predictor element address.
- w2  output  DATA_W  predictor write data.
- decision_in  input  3  predictor decision.
- result  output  3  captured decision, held until the next capture.
- result_valid  output  1  one-cycle pulse when result updates.
- busy  output  1  high in any state other than IDLE.

Behaviour:
Reset (wb_rst_n low at a rising edge):
- State goes to IDLE.
- mat_sel = 2'b11, adr = 0, w2 = 0, result = 0, result_valid = 0, busy = 0.
- Word and settle counters clear.
- Applies in any state, including mid-load. No partial write cycle is emitted after reset.

Output registers:
- mat_sel, adr, w2, result and result_valid are registered.
- in_ready is combinational: (state == LOAD) && !abort.

FSM states: IDLE, LOAD, SETTLE, DONE.

IDLE:
- mat_sel = 11.
- start = 1 → LOAD. Word count clears. Total count is latched as 12 if reload_weights = 1, else 4.

LOAD:
- Handshake = in_valid && in_ready.
- On a handshake at edge N, during cycle N+1 the outputs are:
  - mat_sel = word_cnt[3:2];
  - adr = word_cnt[1:0];
  - w2 = in_data;
  - then word_cnt increments.
- Cycles with no handshake drive mat_sel = 11. Each accepted word therefore produces exactly one write cycle.
- Back-to-back handshakes are allowed (one word per cycle, full throughput). in_valid gaps are allowed.
- On the handshake of the final word (word_cnt = total − 1) → SETTLE, with the settle counter loaded with SETTLE_CYCLES.

SETTLE:
- The first cycle carries the final write. mat_sel returns to 11 after it.
- The counter decrements each cycle.
- When the counter reaches 0 → DONE. Exact timing: the final handshake is at edge N, DONE is entered at edge N+SETTLE_CYCLES.

DONE (one cycle):
- result <= decision_in and result_valid = 1 on the following cycle.
- → IDLE.
- result_valid is therefore high exactly SETTLE_CYCLES+1 cycles after the final handshake edge.

abort:
- In LOAD or SETTLE: at that edge go to IDLE.
  - The next cycle drives mat_sel = 11.
  - A word offered in the abort cycle is not accepted.
  - result and result_valid are unchanged.
- abort in IDLE or DONE has no effect.
- abort and start together in IDLE: start wins (abort is ignored in IDLE).

Other rules:
- start while busy is ignored.
- reload_weights is sampled only with an accepted start.
- in_data passes to w2 unmodified; no sign or width change.
- The word counter never wraps: it cannot exceed total − 1, because LOAD exits at the last word.

Test Plan:
- Full load: start with reload_weights = 1, then 12 back-to-back words 1..12.
  - Required: writes (mat_sel, adr, w2) = (00,0,1), (00,1,2) … (10,3,12) on 12 consecutive cycles.
  - mat_sel = 11 before and after; busy stays high throughout.
- Input-only load: start with reload_weights = 0 and 4 words −5, 7, 0, 3.
  - Required: only mat_sel = 00 writes, adr 0..3, w2 = 21-bit two's complement of −5 (0x1FFFFB).
  - The 5th offered word sees in_ready = 0.
- Capture: decision_in held at 3'd5, SETTLE_CYCLES = 2.
  - Required: result_valid pulses exactly 3 cycles after the final handshake edge; result = 5 and stays 5 after the pulse.
- Gappy source: in_valid toggles 1,0,0,1… across the 12 words.
  - Required: write cycles occur only after handshakes; mat_sel = 11 in the gaps; order and values identical to the full-load case.
- Abort at word 6.
  - Required: IDLE next cycle, in_ready = 0, mat_sel = 11, no result_valid.
  - A following full load starts again at (00,0).
- Reset mid-SETTLE (wb_rst_n low for 1 cycle).
  - Required: all outputs at reset values, no result_valid.
  - start while busy (mid-LOAD) is ignored and the word sequence continues unaffected.

Source files
------------

// File: rtl/nn_mat_loader.sv
// Purpose : host-side sequencer that streams signed words into the 2x2 predictor's
//           matrix-load pins and captures its 3-bit decision afterwards.
// Latency : one write cycle per accepted word, issued the cycle after the handshake;
//           result_valid pulses SETTLE_CYCLES+1 cycles after the final handshake edge.
// Backpr. : in_ready is high only in LOAD without abort; words are accepted at full
//           rate, and gaps on in_valid simply produce idle (mat_sel = 11) cycles.
//
// Ports:
//   wb_clk_i, wb_rst_n        clock and synchronous active-low reset
//   start, reload_weights     begin a sequence (12 words if reload_weights, else 4)
//   abort                     cancel a sequence in LOAD or SETTLE
//   in_valid/in_ready/in_data word stream in
//   mat_sel, adr, w2          predictor write pins (mat_sel 2'b11 = no write)
//   decision_in               predictor decision
//   result, result_valid      captured decision and its one-cycle strobe
//   busy                      sequencer not idle
module nn_mat_loader #(
    parameter int DATA_W        = 21,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              start,
    input  logic              reload_weights,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [1:0]        mat_sel,
    output logic [1:0]        adr,
    output logic [DATA_W-1:0] w2,
    input  logic [2:0]        decision_in,
    output logic [2:0]        result,
    output logic              result_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] word_cnt;
    logic [3:0] total;
    logic [3:0] settle_cnt;
    logic       hs;
    logic       last_word;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and combinational outputs
    always_comb begin
        state_nxt = state;
        in_ready  = (state == LOAD) && !abort;
        hs        = in_valid && in_ready;
        last_word = (word_cnt == (total - 4'd1));
        busy      = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (hs && last_word) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // Counter holds 1 on the edge that completes SETTLE_CYCLES
                // cycles since the final handshake.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (settle_cnt <= 4'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            mat_sel      <= 2'b11;
            adr          <= 2'b00;
            w2           <= '0;
            result       <= 3'd0;
            result_valid <= 1'b0;
            word_cnt     <= 4'd0;
            total        <= 4'd0;
            settle_cnt   <= 4'd0;
        end else begin
            // A write lasts exactly one cycle; every other cycle is idle.
            mat_sel      <= 2'b11;
            result_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        word_cnt <= 4'd0;
                        total    <= reload_weights ? 4'd12 : 4'd4;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        mat_sel <= word_cnt[3:2];
                        adr     <= word_cnt[1:0];
                        w2      <= in_data;
                        if (last_word) begin
                            settle_cnt <= 4'(SETTLE_CYCLES);
                        end else begin
                            word_cnt <= word_cnt + 4'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (!abort) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                DONE: begin
                    result       <= decision_in;
                    result_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_mat_loader.sv
// Purpose : self-checking bench for nn_mat_loader using write/result scoreboards.
// Latency : expects each write the cycle after its handshake and result_valid
//           SETTLE_CYCLES+1 cycles after the final handshake edge.
// Backpr. : driver holds in_valid until in_ready is seen, bounded per word.
module tb_nn_mat_loader;

    localparam int DATA_W        = 21;
    localparam int SETTLE_CYCLES = 2;

    logic              wb_clk_i;
    logic              wb_rst_n;
    logic              start;
    logic              reload_weights;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        mat_sel;
    logic [1:0]        adr;
    logic [DATA_W-1:0] w2;
    logic [2:0]        decision_in;
    logic [2:0]        result;
    logic              result_valid;
    logic              busy;

    nn_mat_loader #(
        .DATA_W        (DATA_W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_n       (wb_rst_n),
        .start          (start),
        .reload_weights (reload_weights),
        .abort          (abort),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .mat_sel        (mat_sel),
        .adr            (adr),
        .w2             (w2),
        .decision_in    (decision_in),
        .result         (result),
        .result_valid   (result_valid),
        .busy           (busy)
    );

    typedef struct {
        logic [1:0]        sel;
        logic [1:0]        adr;
        logic [DATA_W-1:0] w;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];

    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic mon_en = 1'b0;
    logic prev_hs = 1'b0;

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    always @(posedge wb_clk_i) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every write must follow a handshake and match the scoreboard;
    // every result strobe must arrive on its predicted cycle.
    always @(negedge wb_clk_i) begin
        if (mon_en) begin
            wr_t  e;
            res_t r;
            chk("wr_timing", 32'(mat_sel != 2'b11), 32'(prev_hs));
            if (mat_sel != 2'b11) begin
                chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    chk("wr_sel", 32'(mat_sel), 32'(e.sel));
                    chk("wr_adr", 32'(adr), 32'(e.adr));
                    chk("wr_w2", 32'(w2), 32'(e.w));
                end
            end
            if (result_valid) begin
                chk("rv_expected", 32'(res_q.size() != 0), 32'd1);
                if (res_q.size() != 0) begin
                    r = res_q.pop_front();
                    chk("rv_cycle", 32'(cyc), 32'(r.cyc));
                    chk("result", 32'(result), 32'(r.val));
                end
            end
            prev_hs = in_valid && in_ready;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_word(input int idx, input logic [DATA_W-1:0] d, input bit last);
        bit got;
        wr_t e;
        got      = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge wb_clk_i);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        chk("hs_timeout", 32'(got), 32'd1);
        if (got) begin
            chk("busy_load", 32'(busy), 32'd1);
            e.sel = 2'(idx >> 2);
            e.adr = 2'(idx & 3);
            e.w   = d;
            wr_q.push_back(e);
            if (last) res_q.push_back('{cyc + SETTLE_CYCLES + 2, decision_in});
        end
        @(posedge wb_clk_i);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic reload);
        start          = 1'b1;
        reload_weights = reload;
        @(posedge wb_clk_i);
        #1;
        start          = 1'b0;
        reload_weights = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge wb_clk_i);
            if (!busy && res_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("idle_timeout", 32'(ok), 32'd1);
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic full_load(input int gap);
        do_start(1'b1);
        for (int i = 0; i < 12; i++) begin
            send_word(i, DATA_W'(i + 1), i == 11);
            repeat (gap) @(posedge wb_clk_i);
            if (gap > 0) #1;
        end
        wait_idle();
    endtask

    initial begin
        logic [DATA_W-1:0] neg_words [4];
        neg_words[0] = DATA_W'(-5);
        neg_words[1] = DATA_W'(7);
        neg_words[2] = DATA_W'(0);
        neg_words[3] = DATA_W'(3);

        wb_rst_n       = 1'b0;
        start          = 1'b0;
        reload_weights = 1'b0;
        abort          = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        decision_in    = 3'd5;
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_n = 1'b1;
        @(negedge wb_clk_i);
        chk("rst_mat_sel", 32'(mat_sel), 32'h3);
        chk("rst_adr", 32'(adr), 32'h0);
        chk("rst_w2", 32'(w2), 32'h0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_rv", 32'(result_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        prev_hs = 1'b0;
        mon_en  = 1'b1;
        @(posedge wb_clk_i);
        #1;

        // Full back-to-back load with capture of decision 5
        full_load(0);
        repeat (3) @(negedge wb_clk_i);
        chk("result_hold", 32'(result), 32'd5);
        chk("rv_low_after", 32'(result_valid), 32'd0);
        @(posedge wb_clk_i);
        #1;

        // Input-only load with a negative word, then a refused 5th word
        decision_in = 3'd3;
        do_start(1'b0);
        for (int i = 0; i < 4; i++) send_word(i, neg_words[i], i == 3);
        in_valid = 1'b1;
        in_data  = DATA_W'(99);
        @(negedge wb_clk_i);
        chk("fifth_in_ready", 32'(in_ready), 32'd0);
        @(posedge wb_clk_i);
        #1;
        in_valid = 1'b0;
        wait_idle();
        chk("result_input_only", 32'(result), 32'd3);

        // Gappy source: in_valid 1,0,0,1...
        decision_in = 3'd2;
        full_load(2);

        // Abort after 6 words; offered word must not be taken
        decision_in = 3'd6;
        do_start(1'b1);
        for (int i = 0; i < 6; i++) send_word(i, DATA_W'(100 + i), 1'b0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = DATA_W'(555);
        @(negedge wb_clk_i);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(posedge wb_clk_i);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge wb_clk_i);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready_after", 32'(in_ready), 32'd0);
        chk("abort_mat_sel", 32'(mat_sel), 32'h3);
        chk("abort_result_kept", 32'(result), 32'd2);
        @(posedge wb_clk_i);
        #1;
        full_load(0);
        chk("result_after_abort", 32'(result), 32'd6);

        // start ignored mid-LOAD, then reset during SETTLE
        decision_in = 3'd7;
        do_start(1'b1);
        for (int i = 0; i < 12; i++) begin
            send_word(i, DATA_W'(200 + i), i == 11);
            if (i == 4) begin
                start          = 1'b1;
                reload_weights = 1'b0;
                @(posedge wb_clk_i);
                #1;
                start = 1'b0;
            end
        end
        wb_rst_n = 1'b0;
        @(posedge wb_clk_i);
        #1;
        res_q.delete();
        wb_rst_n = 1'b1;
        @(negedge wb_clk_i);
        chk("mid_rst_mat_sel", 32'(mat_sel), 32'h3);
        chk("mid_rst_adr", 32'(adr), 32'h0);
        chk("mid_rst_w2", 32'(w2), 32'h0);
        chk("mid_rst_result", 32'(result), 32'h0);
        chk("mid_rst_rv", 32'(result_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        repeat (6) @(negedge wb_clk_i);
        chk("mid_rst_no_rv", 32'(result_valid), 32'h0);
        chk("mid_rst_result_still0", 32'(result), 32'h0);

        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        chk("res_q_empty", 32'(res_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
